// File: rtl/pulse_stream_gen.sv
// pulse_stream_gen: AXI-stream source emitting baseline gaps followed by sloped, saturated pulses
module pulse_stream_gen #(
    parameter int WIDTH       = 8,
    parameter int LEN_WIDTH   = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] cfg_baseline,
    input  logic signed [WIDTH-1:0] cfg_amplitude,
    input  logic signed [WIDTH-1:0] cfg_slope,
    input  logic [LEN_WIDTH-1:0]    cfg_pulse_length,
    input  logic [LEN_WIDTH-1:0]    cfg_gap,
    input  logic [COUNT_WIDTH-1:0]  cfg_pulse_count,
    input  logic                    start,
    input  logic                    stop,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [WIDTH-1:0]        m_tdata,
    output logic                    m_tlast
);
    localparam int AW = WIDTH + LEN_WIDTH + 2;
    localparam logic signed [AW-1:0] HI = AW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] LO = ~HI;

    typedef enum logic [1:0] {IDLE, GAP, PULSE} state_t;

    state_t                  state;
    logic signed [WIDTH-1:0] base_r, amp_r, slope_r;
    logic [LEN_WIDTH-1:0]    len_r, gap_r, cnt;
    logic [COUNT_WIDTH-1:0]  count_r, pcnt;
    logic signed [AW-1:0]    acc, acc_n, s0, s0_in;
    logic                    stop_p, fire, stop_eff, pulse_end, run_end;

    function automatic logic [WIDTH-1:0] sat(input logic signed [AW-1:0] v);
        return v > HI ? HI[WIDTH-1:0] : v < LO ? LO[WIDTH-1:0] : v[WIDTH-1:0];
    endfunction

    // Beat retirement, first-sample values and end-of-run decision
    always_comb begin
        fire      = m_tvalid && m_tready;
        stop_eff  = stop_p || stop;
        s0        = AW'(base_r) + AW'(amp_r);
        s0_in     = AW'(cfg_baseline) + AW'(cfg_amplitude);
        acc_n     = acc + AW'(slope_r);
        pulse_end = state == PULSE && cnt == len_r - 1'b1;
        run_end   = (state == GAP && stop_eff) ||
                    (pulse_end && (stop_eff || (count_r != '0 && pcnt + 1'b1 == count_r)));
    end

    // Sequencer: the registered outputs always hold the beat currently presented
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            stop_p   <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            if (busy) stop_p <= stop_p | stop;
            case (state)
                IDLE: if (start) begin
                    if (cfg_pulse_length == '0) cfg_err <= 1'b1;
                    else begin
                        base_r   <= cfg_baseline;
                        amp_r    <= cfg_amplitude;
                        slope_r  <= cfg_slope;
                        len_r    <= cfg_pulse_length;
                        gap_r    <= cfg_gap;
                        count_r  <= cfg_pulse_count;
                        busy     <= 1'b1;
                        m_tvalid <= 1'b1;
                        pcnt     <= '0;
                        stop_p   <= 1'b0;
                        cnt      <= '0;
                        if (cfg_gap != '0) begin
                            state   <= GAP;
                            m_tdata <= cfg_baseline;
                            m_tlast <= 1'b0;
                        end else begin
                            state   <= PULSE;
                            acc     <= s0_in;
                            m_tdata <= sat(s0_in);
                            m_tlast <= cfg_pulse_length == LEN_WIDTH'(1);
                        end
                    end
                end
                default: if (fire) begin
                    if (run_end) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        m_tvalid <= 1'b0;
                        m_tlast  <= 1'b0;
                        done     <= 1'b1;
                    end else if (state == PULSE && !pulse_end) begin
                        cnt     <= cnt + 1'b1;
                        acc     <= acc_n;
                        m_tdata <= sat(acc_n);
                        m_tlast <= cnt + 1'b1 == len_r - 1'b1;
                    end else if (state == GAP && cnt != gap_r - 1'b1) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (pulse_end) pcnt <= pcnt + 1'b1;
                        if (pulse_end && gap_r != '0) begin
                            state   <= GAP;
                            m_tdata <= base_r;
                            m_tlast <= 1'b0;
                        end else begin
                            state   <= PULSE;
                            acc     <= s0;
                            m_tdata <= sat(s0);
                            m_tlast <= len_r == LEN_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule
